// File: rtl/bbq_pkg.sv
// Shared encodings for the barbeque steak grader: FSM states, doneness levels
// and the points each level is worth.
package bbq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOKING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [2:0] LVL_RAW   = 3'd0;
  localparam logic [2:0] LVL_RARE  = 3'd1;
  localparam logic [2:0] LVL_MED   = 3'd2;
  localparam logic [2:0] LVL_WELL  = 3'd3;
  localparam logic [2:0] LVL_BURNT = 3'd4;

  localparam logic [2:0] PTS_RAW   = 3'd0;
  localparam logic [2:0] PTS_RARE  = 3'd2;
  localparam logic [2:0] PTS_MED   = 3'd3;
  localparam logic [2:0] PTS_WELL  = 3'd1;
  localparam logic [2:0] PTS_BURNT = 3'd0;

  function automatic logic [2:0] level_points(input logic [2:0] lvl);
    case (lvl)
      LVL_RARE: level_points = PTS_RARE;
      LVL_MED:  level_points = PTS_MED;
      LVL_WELL: level_points = PTS_WELL;
      LVL_BURNT: level_points = PTS_BURNT;
      default:  level_points = PTS_RAW;
    endcase
  endfunction

endpackage

// File: rtl/doneness_grade.sv
// Combinational grade of one steak side: cooked seconds to doneness level and
// the points that level earns at serving time.
module doneness_grade
  import bbq_pkg::*;
#(
  parameter int TIME_W  = 6,
  parameter int T_RARE  = 4,
  parameter int T_MED   = 7,
  parameter int T_WELL  = 10,
  parameter int T_BURNT = 14
) (
  input  logic [TIME_W-1:0] i_time,
  output logic [2:0]        o_level,
  output logic [2:0]        o_points
);

  localparam logic [TIME_W-1:0] L_RARE  = TIME_W'(T_RARE);
  localparam logic [TIME_W-1:0] L_MED   = TIME_W'(T_MED);
  localparam logic [TIME_W-1:0] L_WELL  = TIME_W'(T_WELL);
  localparam logic [TIME_W-1:0] L_BURNT = TIME_W'(T_BURNT);

  always_comb begin
    o_level = LVL_RAW;
    if (i_time >= L_BURNT)     o_level = LVL_BURNT;
    else if (i_time >= L_WELL) o_level = LVL_WELL;
    else if (i_time >= L_MED)  o_level = LVL_MED;
    else if (i_time >= L_RARE) o_level = LVL_RARE;
  end

  assign o_points = level_points(o_level);

endmodule

// File: rtl/steak_doneness.sv
// Steak grill controller: gates the one-second counter, counts its go toggles
// into per-side cook time, and grades the steak when served or burnt.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no steak cooking; outputs hold the last round's results
//   ST_COOKING | counter enabled; ticks credited to the side on the grill
//   ST_DONE    | single cycle; score presented with score_valid
module steak_doneness
  import bbq_pkg::*;
#(
  parameter int TIME_W  = 6,
  parameter int T_RARE  = 4,
  parameter int T_MED   = 7,
  parameter int T_WELL  = 10,
  parameter int T_BURNT = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              start,
  input  logic              flip,
  input  logic              serve,
  output logic              cook_en,
  output logic              side,
  output logic [TIME_W-1:0] time_a,
  output logic [TIME_W-1:0] time_b,
  output logic [2:0]        level_a,
  output logic [2:0]        level_b,
  output logic [2:0]        score,
  output logic              score_valid,
  output logic              burnt
);

  localparam logic [TIME_W-1:0] L_MAX   = {TIME_W{1'b1}};
  localparam logic [TIME_W-1:0] L_BURNT = TIME_W'(T_BURNT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_go_q;
  logic              r_side;
  logic              r_burnt;
  logic [TIME_W-1:0] r_time_a;
  logic [TIME_W-1:0] r_time_b;
  logic [2:0]        r_score;

  logic              w_tick;
  logic              w_cooking;
  logic [TIME_W-1:0] w_on_time;
  logic [TIME_W-1:0] w_on_inc;
  logic              w_burn_hit;
  logic [2:0]        w_pts_a;
  logic [2:0]        w_pts_b;
  logic [2:0]        w_score_calc;

  assign w_tick    = go ^ r_go_q;
  assign w_cooking = (r_state == ST_COOKING);
  assign w_on_time = r_side ? r_time_b : r_time_a;
  assign w_on_inc  = (w_on_time == L_MAX) ? w_on_time : w_on_time + 1'b1;
  // serve takes priority, so a tick coinciding with serve never burns
  assign w_burn_hit = w_cooking && w_tick && !serve && (w_on_inc >= L_BURNT);

  doneness_grade #(
    .TIME_W(TIME_W), .T_RARE(T_RARE), .T_MED(T_MED), .T_WELL(T_WELL), .T_BURNT(T_BURNT)
  ) u_grade_a (
    .i_time  (r_time_a),
    .o_level (level_a),
    .o_points(w_pts_a)
  );

  doneness_grade #(
    .TIME_W(TIME_W), .T_RARE(T_RARE), .T_MED(T_MED), .T_WELL(T_WELL), .T_BURNT(T_BURNT)
  ) u_grade_b (
    .i_time  (r_time_b),
    .o_level (level_b),
    .o_points(w_pts_b)
  );

  assign w_score_calc = r_burnt ? 3'd0 : (w_pts_a + w_pts_b);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_COOKING;
      ST_COOKING: if (serve || w_burn_hit) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_go_q   <= 1'b0;
      r_side   <= 1'b0;
      r_burnt  <= 1'b0;
      r_time_a <= '0;
      r_time_b <= '0;
      r_score  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_go_q  <= go;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_side   <= 1'b0;
            r_burnt  <= 1'b0;
            r_time_a <= '0;
            r_time_b <= '0;
          end
        end
        ST_COOKING: begin
          if (!serve) begin
            // tick goes to the pre-flip side
            if (w_tick) begin
              if (r_side) r_time_b <= w_on_inc;
              else        r_time_a <= w_on_inc;
            end
            if (flip)       r_side  <= ~r_side;
            if (w_burn_hit) r_burnt <= 1'b1;
          end
        end
        ST_DONE: r_score <= w_score_calc;
        default: ;
      endcase
    end
  end

  assign cook_en     = w_cooking;
  assign side        = r_side;
  assign time_a      = r_time_a;
  assign time_b      = r_time_b;
  assign burnt       = r_burnt;
  assign score_valid = (r_state == ST_DONE);
  // during DONE the fresh grade is shown directly; afterwards the latched copy holds
  assign score       = (r_state == ST_DONE) ? w_score_calc : r_score;

endmodule

// File: doc/steak_doneness.md
Name: steak_doneness

Overview:
- Downstream consumer of the one-second steak counter's `go` output in the barbeque game.
- Gates that counter via `cook_en`, which drives its clock enable.
- Detects each `go` toggle as one elapsed second of cooking.
- Accumulates cook time per steak side, tracks which side faces the grill, and grades the steak into a score when the player serves it or it burns.

Parameters:
- TIME_W, 6, width of each per-side seconds accumulator (saturating).
- T_RARE, 4, seconds at which a side becomes RARE.
- T_MED, 7, seconds at which a side becomes MEDIUM.
- T_WELL, 10, seconds at which a side becomes WELL.
- T_BURNT, 14, seconds at which a side becomes BURNT; ends the round.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- go  in  1  toggle from the steak counter; each edge of either polarity = 1 s
- start  in  1  single-cycle pulse: place a new steak on the grill
- flip  in  1  single-cycle pulse: swap the side facing the grill
- serve  in  1  single-cycle pulse: take the steak off the grill
- cook_en  out  1  clock enable to the steak counter; high only in COOKING
- side  out  1  side currently on the grill (0 = A, 1 = B)
- time_a  out  TIME_W  seconds cooked on side A
- time_b  out  TIME_W  seconds cooked on side B
- level_a  out  3  doneness of side A: 0 RAW, 1 RARE, 2 MEDIUM, 3 WELL, 4 BURNT
- level_b  out  3  doneness of side B, same encoding
- score  out  3  grade of the last finished round, 0..6
- score_valid  out  1  one-cycle pulse when `score` updates
- burnt  out  1  high from a burn until the next start

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state IDLE; cook_en 0; side 0; time_a and time_b 0.
  - score 0; score_valid 0; burnt 0; go_q 0.
- Tick detection:
  - go_q <= go every cycle.
  - tick = go ^ go_q, counted only in COOKING; ticks in other states are discarded.
  - Latency: go edge at cycle n → time_x increments at cycle n+1 edge, visible at n+1.
- Per-side time:
  - A tick adds 1 to the side currently on the grill.
  - The accumulator saturates at 2^TIME_W−1, never wraps.
- Levels (combinational from time):
  - time ≥ T_BURNT → 4; ≥ T_WELL → 3; ≥ T_MED → 2; ≥ T_RARE → 1; else 0.
- FSM states: IDLE, COOKING, DONE.
- IDLE:
  - cook_en 0.
  - start → COOKING; clears time_a, time_b, side, burnt.
  - flip and serve are ignored.
- COOKING:
  - cook_en 1.
  - flip toggles side.
  - If serve is asserted → DONE.
  - Else if a tick would take the on-grill side to T_BURNT: apply the tick, set burnt, → DONE.
  - start is ignored.
- DONE (exactly 1 cycle):
  - cook_en 0.
  - score loaded; score_valid 1.
  - → IDLE.
- Score:
  - Per-side points: RAW 0, RARE 2, MEDIUM 3, WELL 1, BURNT 0.
  - score = points(A) + points(B), computed from the times frozen on leaving COOKING.
  - score = 0 whenever burnt is set.
- Simultaneous events:
  - tick + flip: the tick is credited to the side before the flip.
  - serve + tick: serve wins, the tick is dropped, no burn check.
  - serve + flip: serve wins, side unchanged.
  - start while COOKING or DONE: ignored.
- Outputs hold their last values in IDLE, so the display keeps the final round until the next start.
- The upstream counter self-clears whenever cook_en is low, so each round begins at a fresh second boundary. Its go may be left at 1; go_q tracks it in IDLE, so no spurious tick is counted on start.

Decomposition:
- Shared package `bbq_pkg`:
  - doneness encoding constants: LVL_RAW, LVL_RARE, LVL_MED, LVL_WELL, LVL_BURNT.
  - FSM state constants.
  - per-level point constants.
- One natural sub-module, `doneness_grade`:
  - purely combinational, instantiated twice (once per side).
  - maps a time to a level and a point value.
- FSM, edge detect, and accumulators live in the top block.

Test Plan:
- Reset mid-round: start, 5 ticks, assert reset 1 cycle → all outputs 0, state IDLE, cook_en 0; following go edges leave time_a at 0.
- Perfect steak: start, 8 ticks, flip, 8 ticks, serve → time_a 8, time_b 8, levels 2/2, score 6, score_valid high exactly 1 cycle, cook_en 0 the cycle after serve.
- Burn: start, 14 ticks with no flip → time_a 14, level_a 4, burnt 1, score 0, score_valid pulse; further go edges leave time_a at 14.
- Simultaneous tick + flip: time_a 3; go edge coincident with flip → time_a 4, time_b 0, side 1; next tick → time_b 1.
- Serve coincident with tick: time_a 13; serve on the same cycle as a go edge → time_a stays 13, burnt 0, score = points(WELL)+points(RAW) = 1.
- Ignored inputs: flip/serve in IDLE, start during COOKING with time_a 5 → no state change, time_a stays 5, side unchanged, no score_valid.
